// File: rtl/fp_exp_align.sv
// Exponent-compare / operand-swap stage of the single-precision FP adder: unpack, order by magnitude,
// emit unshifted mantissas and saturated right-shift amount. Optional FP_SPECIAL_DETECT_EN adds NaN/Inf/zero classification.
module fp_exp_align #(
    parameter int EXP_W     = 8,
    parameter int FRAC_W    = 23,
    parameter int SAT_SHIFT = 25
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   op_a,
    input  logic [EXP_W+FRAC_W:0]   op_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [FRAC_W:0]         big_mant,
    output logic [FRAC_W:0]         small_mant,
    output logic [7:0]              shift_amt,
    output logic [EXP_W-1:0]        exp_out,
    output logic                    sign_big,
    output logic                    eff_sub,
    output logic                    swapped,
    output logic [1:0]              special
);
    localparam int          OP_W   = EXP_W + FRAC_W + 1;
    localparam logic [31:0] SAT_U  = 32'(SAT_SHIFT);

    // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // valid and its data hold until that transfer, and ready may depend on the downstream ready.
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_en, s2_en, s1_load, s2_load;

    assign s2_en    = !s2_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign s1_load  = s1_en && in_valid;
    assign s2_load  = s2_en && s1_valid_q;
    assign in_ready = s1_en;

    assign s1_valid_d = s1_en ? in_valid : s1_valid_q;
    assign s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;

    // Stage 1: unpack; a zero exponent field means denormal with effective exponent 1
    logic [EXP_W-1:0]  exp_a_raw, exp_b_raw;
    logic [FRAC_W-1:0] frac_a, frac_b;
    logic [EXP_W-1:0]  exp_a_d, exp_b_d;
    logic [FRAC_W:0]   mant_a_d, mant_b_d;

    assign exp_a_raw = op_a[OP_W-2 -: EXP_W];
    assign exp_b_raw = op_b[OP_W-2 -: EXP_W];
    assign frac_a    = op_a[FRAC_W-1:0];
    assign frac_b    = op_b[FRAC_W-1:0];
    assign exp_a_d   = (exp_a_raw == '0) ? EXP_W'(1) : exp_a_raw;
    assign exp_b_d   = (exp_b_raw == '0) ? EXP_W'(1) : exp_b_raw;
    assign mant_a_d  = {(exp_a_raw != '0), frac_a};
    assign mant_b_d  = {(exp_b_raw != '0), frac_b};

    logic              s1_sign_a_q, s1_sign_b_q;
    logic [EXP_W-1:0]  s1_exp_a_q, s1_exp_b_q;
    logic [FRAC_W:0]   s1_mant_a_q, s1_mant_b_q;

    // Stage 2: magnitude compare on {effective exponent, mantissa}; full tie keeps A as big
    logic              a_big;
    logic [EXP_W-1:0]  big_exp, small_exp, diff;
    logic [FRAC_W:0]   big_mant_d, small_mant_d;
    logic [7:0]        shift_amt_d;
    logic              sign_big_d, eff_sub_d, swapped_d;

    always_comb begin
        a_big = (s1_exp_a_q > s1_exp_b_q) ||
                ((s1_exp_a_q == s1_exp_b_q) && (s1_mant_a_q >= s1_mant_b_q));
        big_exp      = a_big ? s1_exp_a_q  : s1_exp_b_q;
        small_exp    = a_big ? s1_exp_b_q  : s1_exp_a_q;
        big_mant_d   = a_big ? s1_mant_a_q : s1_mant_b_q;
        small_mant_d = a_big ? s1_mant_b_q : s1_mant_a_q;
        sign_big_d   = a_big ? s1_sign_a_q : s1_sign_b_q;
        eff_sub_d    = s1_sign_a_q ^ s1_sign_b_q;
        swapped_d    = !a_big;
        diff         = big_exp - small_exp;
        if (32'(diff) > SAT_U) shift_amt_d = 8'(SAT_SHIFT);
        else                   shift_amt_d = 8'(diff);
    end

    logic [FRAC_W:0]  big_mant_q, small_mant_q;
    logic [7:0]       shift_amt_q;
    logic [EXP_W-1:0] exp_out_q;
    logic             sign_big_q, eff_sub_q, swapped_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s1_sign_a_q  <= 1'b0;
            s1_sign_b_q  <= 1'b0;
            s1_exp_a_q   <= '0;
            s1_exp_b_q   <= '0;
            s1_mant_a_q  <= '0;
            s1_mant_b_q  <= '0;
            big_mant_q   <= '0;
            small_mant_q <= '0;
            shift_amt_q  <= '0;
            exp_out_q    <= '0;
            sign_big_q   <= 1'b0;
            eff_sub_q    <= 1'b0;
            swapped_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s1_load) begin
                s1_sign_a_q <= op_a[OP_W-1];
                s1_sign_b_q <= op_b[OP_W-1];
                s1_exp_a_q  <= exp_a_d;
                s1_exp_b_q  <= exp_b_d;
                s1_mant_a_q <= mant_a_d;
                s1_mant_b_q <= mant_b_d;
            end
            if (s2_load) begin
                big_mant_q   <= big_mant_d;
                small_mant_q <= small_mant_d;
                shift_amt_q  <= shift_amt_d;
                exp_out_q    <= big_exp;
                sign_big_q   <= sign_big_d;
                eff_sub_q    <= eff_sub_d;
                swapped_q    <= swapped_d;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign big_mant   = big_mant_q;
    assign small_mant = small_mant_q;
    assign shift_amt  = shift_amt_q;
    assign exp_out    = exp_out_q;
    assign sign_big   = sign_big_q;
    assign eff_sub    = eff_sub_q;
    assign swapped    = swapped_q;

`ifdef FP_SPECIAL_DETECT_EN
    // Class bits per operand: {nan, inf, zero}, captured alongside the unpacked fields
    logic [2:0] cls_a_d, cls_b_d;
    logic [2:0] s1_cls_a_q, s1_cls_b_q;
    logic [1:0] special_d, special_q;

    assign cls_a_d = {(&exp_a_raw) && (|frac_a), (&exp_a_raw) && !(|frac_a),
                      (exp_a_raw == '0) && !(|frac_a)};
    assign cls_b_d = {(&exp_b_raw) && (|frac_b), (&exp_b_raw) && !(|frac_b),
                      (exp_b_raw == '0) && !(|frac_b)};

    always_comb begin
        special_d = 2'b00;
        if (s1_cls_a_q[2] || s1_cls_b_q[2] || (s1_cls_a_q[1] && s1_cls_b_q[1] && eff_sub_d))
            special_d = 2'b11;
        else if (s1_cls_a_q[1] || s1_cls_b_q[1])
            special_d = 2'b10;
        else if (s1_cls_a_q[0] && s1_cls_b_q[0])
            special_d = 2'b01;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_cls_a_q <= '0;
            s1_cls_b_q <= '0;
            special_q  <= 2'b00;
        end else begin
            if (s1_load) begin
                s1_cls_a_q <= cls_a_d;
                s1_cls_b_q <= cls_b_d;
            end
            if (s2_load) special_q <= special_d;
        end
    end

    assign special = special_q;
`else
    assign special = 2'b00;
`endif

endmodule

// File: tb/tb_fp_exp_align.sv
// Bench for fp_exp_align: directed vectors, stall/reset scenarios and randomized traffic against an arithmetic reference model.
module tb_fp_exp_align;
    localparam int VW = 69;
`ifdef FP_SPECIAL_DETECT_EN
    localparam bit SPEC_EN = 1'b1;
`else
    localparam bit SPEC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        in_ready, out_valid, sign_big, eff_sub, swapped;
    logic [23:0] big_mant, small_mant;
    logic [7:0]  shift_amt, exp_out;
    logic [1:0]  special;
    logic [VW-1:0] out_vec;

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_ready = 1'b0;
    bit prev_stall = 1'b0;
    logic [VW-1:0] prev_vec;
    logic [VW-1:0] exp_q[$];

    fp_exp_align dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
        .big_mant(big_mant), .small_mant(small_mant), .shift_amt(shift_amt),
        .exp_out(exp_out), .sign_big(sign_big), .eff_sub(eff_sub),
        .swapped(swapped), .special(special)
    );

    assign out_vec = {big_mant, small_mant, shift_amt, exp_out, sign_big, eff_sub, swapped, special};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: order by numeric magnitude of (effective exponent, mantissa), then derive fields
    function automatic logic [VW-1:0] ref_model(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, fa, fb, ma, mb, be, se, diff, sh;
        longint ka, kb;
        bit a_big, nan_a, nan_b, inf_a, inf_b, z_a, z_b, sgn;
        logic [1:0] sp;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        fa = int'(a[22:0]);  fb = int'(b[22:0]);
        ma = (ea == 0) ? fa : fa + 8388608;
        mb = (eb == 0) ? fb : fb + 8388608;
        nan_a = (ea == 255) && (fa != 0); inf_a = (ea == 255) && (fa == 0); z_a = (ea == 0) && (fa == 0);
        nan_b = (eb == 255) && (fb != 0); inf_b = (eb == 255) && (fb == 0); z_b = (eb == 0) && (fb == 0);
        if (ea == 0) ea = 1;
        if (eb == 0) eb = 1;
        ka = longint'(ea) * 16777216 + longint'(ma);
        kb = longint'(eb) * 16777216 + longint'(mb);
        a_big = (ka >= kb);
        be   = a_big ? ea : eb;
        se   = a_big ? eb : ea;
        diff = be - se;
        sh   = (diff > 25) ? 25 : diff;
        sgn  = a_big ? a[31] : b[31];
        sp   = 2'b00;
        if (SPEC_EN) begin
            if (nan_a || nan_b || (inf_a && inf_b && (a[31] != b[31]))) sp = 2'b11;
            else if (inf_a || inf_b) begin
                sp  = 2'b10;
                sgn = inf_a ? a[31] : b[31];
            end else if (z_a && z_b) sp = 2'b01;
        end
        return {24'(a_big ? ma : mb), 24'(a_big ? mb : ma), 8'(sh), 8'(be),
                sgn, a[31] ^ b[31], !a_big, sp};
    endfunction

    function automatic logic [31:0] rand_op(input logic [31:0] other);
        logic [31:0] tab [8];
        logic        s;
        tab = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                32'h7FC00000, 32'h00000001, 32'h007FFFFF, 32'h3F800000};
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
            0: return $urandom();
            1: return {s, other[30:23], 23'($urandom())};
            2: return {s, other[30:23] ^ 8'($urandom_range(0, 31)), 23'($urandom())};
            3: return tab[$urandom_range(0, 7)];
            4: return {s, 8'h00, 23'($urandom())};
            default: return {s, other[30:0]};
        endcase
    endfunction

    // Monitor: inputs settle at posedge+1, so negedge sees the values the next edge will act on
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", VW'(out_valid), VW'(1));
                check_eq("stall_hold", out_vec, prev_vec);
            end
            check_eq("in_ready", VW'(in_ready), VW'((exp_q.size() == 2 && !out_ready) ? 0 : 1));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check_eq("spurious_out", VW'(1), VW'(0));
                else check_eq("result", out_vec, exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(ref_model(op_a, op_b));
            prev_stall = out_valid && !out_ready;
            prev_vec   = out_vec;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int n;
        bit acc;
        n = 0; acc = 1'b0;
        in_valid = 1'b1; op_a = a; op_b = b;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check_eq("send_timeout", VW'(0), VW'(1));
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output logic [VW-1:0] obs);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = out_valid;
        end
        if (!got) check_eq("out_timeout", VW'(0), VW'(1));
        obs = out_vec;
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic [31:0] a, input logic [31:0] b, output logic [VW-1:0] obs);
        out_ready = 1'b1;
        send(a, b);
        wait_out(obs);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check_eq(tag, VW'(exp_q.size()), VW'(0));
    endtask

    initial begin
        logic [VW-1:0] obs;
        logic [31:0]   a, b;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_outputs", out_vec, VW'(0));
        check_eq("rst_out_valid", VW'(out_valid), VW'(0));
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", VW'(in_ready), VW'(1));

        // 1.0 + 0.5, with latency check
        out_ready = 1'b1;
        send(32'h3F800000, 32'h3F000000);
        check_eq("lat_early", VW'(out_valid), VW'(0));
        @(posedge clk);
        #1;
        check_eq("lat_two", VW'(out_valid), VW'(1));
        check_eq("t1_vec", out_vec, {24'h800000, 24'h800000, 8'd1, 8'h7F, 1'b0, 1'b0, 1'b0, 2'b00});
        @(posedge clk);
        #1;

        run_one(32'h3F000000, 32'hC0000000, obs);
        check_eq("t2_vec", obs, {24'h800000, 24'h800000, 8'd2, 8'h80, 1'b1, 1'b1, 1'b1, 2'b00});
        run_one(32'h3F800000, 32'h3FC00000, obs);
        check_eq("t3_vec", obs, {24'hC00000, 24'h800000, 8'd0, 8'h7F, 1'b0, 1'b0, 1'b1, 2'b00});
        run_one(32'h7F000000, 32'h00000001, obs);
        check_eq("t4_vec", obs, {24'h800000, 24'h000001, 8'd25, 8'hFE, 1'b0, 1'b0, 1'b0, 2'b00});
        run_one(32'h3F800000, 32'h3F800000, obs);
        check_eq("tie_swapped", VW'(obs[2]), VW'(0));

        run_one(32'h7F800000, 32'hFF800000, obs);
        check_eq("sp_inf_sub", VW'(obs[1:0]), VW'(SPEC_EN ? 2'b11 : 2'b00));
        run_one(32'h7FC00000, 32'h3F800000, obs);
        check_eq("sp_nan", VW'(obs[1:0]), VW'(SPEC_EN ? 2'b11 : 2'b00));
        run_one(32'h00000000, 32'h80000000, obs);
        check_eq("sp_zero", VW'(obs[1:0]), VW'(SPEC_EN ? 2'b01 : 2'b00));
        run_one(32'h3F800000, 32'hFF800000, obs);
        check_eq("sp_inf", VW'({obs[4], obs[1:0]}), VW'(SPEC_EN ? 3'b110 : 3'b100));

        // Four back-to-back pairs with a 3-cycle downstream stall
        out_ready = 1'b1;
        fork
            begin
                send(32'h40000000, 32'h3F800000);
                send(32'hC1200000, 32'h41200000);
                send(32'h00400000, 32'h00200000);
                send(32'h42C80000, 32'hBDCCCCCD);
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                #1 check_eq("stall_in_ready", VW'(in_ready), VW'(0));
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("stream_drain");

        // Reset while the pipe is full
        out_ready = 1'b0;
        send(32'h3F800000, 32'h40400000);
        send(32'h40800000, 32'h40A00000);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_valid", VW'(out_valid), VW'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("rst_rel_ready", VW'(in_ready), VW'(1));
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_no_ghost", VW'(out_valid), VW'(0));

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            a = rand_op($urandom());
            b = rand_op(a);
            if ($urandom_range(0, 1) != 0) send(a, b);
            else send(b, a);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
